// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared types and constants for the beta memory arbiter
package beta_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    localparam logic [31:0] ARB_ERR_RDATA = 32'd0;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - per-transfer cycle counter that flags a stuck memory
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_timer;

    // Saturates at LAST so a missed abort can never wrap into a fresh window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (clear) begin
            r_timer <= '0;
        end else if (run && (r_timer != LAST)) begin
            r_timer <= r_timer + W'(1);
        end
    end

    assign expire = run && (r_timer == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes beta instruction and data ports onto one memory
module mem_arbiter
    import beta_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int DATA_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_err,
    output logic        err_sticky
);

    arb_state_t  r_state, w_next_state;
    grant_t      r_last_grant;
    logic        r_m_req, r_m_we, r_i_ack, r_d_ack, r_bus_err, r_err_sticky;
    logic [31:0] r_m_addr, r_m_wdata, r_i_rdata, r_d_rdata;
    logic        w_ireq_ok, w_dreq_ok, w_grant_i, w_grant_d, w_expire, w_done;
    logic [31:0] w_xfer_rdata;

    // A port acked this cycle is ineligible so its still-held req is not re-granted.
    assign w_ireq_ok = i_req & ~r_i_ack;
    assign w_dreq_ok = d_req & ~r_d_ack;
    assign w_done    = (r_state != IDLE) && (m_ack || w_expire);
    assign w_xfer_rdata = !m_ack ? ARB_ERR_RDATA : (r_m_we ? 32'd0 : m_rdata);

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_grant_i | w_grant_d),
        .run    (r_state != IDLE),
        .expire (w_expire)
    );

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ireq_ok && w_dreq_ok) begin
                    w_grant_i = (r_last_grant == GNT_DATA);
                    w_grant_d = (r_last_grant == GNT_INST);
                end else begin
                    w_grant_i = w_ireq_ok;
                    w_grant_d = w_dreq_ok;
                end
                if (w_grant_i)      w_next_state = I_XFER;
                else if (w_grant_d) w_next_state = D_XFER;
            end
            I_XFER, D_XFER: begin
                if (m_ack || w_expire) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= (DATA_FIRST != 0) ? GNT_INST : GNT_DATA;
            r_m_req      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_bus_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_bus_err <= 1'b0;
            if (w_grant_i || w_grant_d) begin
                r_m_req   <= 1'b1;
                r_m_addr  <= w_grant_i ? i_addr : d_addr;
                r_m_we    <= w_grant_d & d_we;
                r_m_wdata <= w_grant_d ? d_wdata : 32'd0;
                if (w_ireq_ok && w_dreq_ok) begin
                    r_last_grant <= w_grant_i ? GNT_INST : GNT_DATA;
                end
            end else if (w_done) begin
                r_m_req   <= 1'b0;
                r_bus_err <= ~m_ack;
                if (!m_ack) r_err_sticky <= 1'b1;
                if (r_state == I_XFER) begin
                    r_i_rdata <= w_xfer_rdata;
                    r_i_ack   <= 1'b1;
                end else begin
                    r_d_rdata <= w_xfer_rdata;
                    r_d_ack   <= 1'b1;
                end
            end
        end
    end

    assign stall      = (i_req & ~r_i_ack) | (d_req & ~r_d_ack);
    assign m_req      = r_m_req;
    assign m_we       = r_m_we;
    assign m_addr     = r_m_addr;
    assign m_wdata    = r_m_wdata;
    assign i_rdata    = r_i_rdata;
    assign i_ack      = r_i_ack;
    assign d_rdata    = r_d_rdata;
    assign d_ack      = r_d_ack;
    assign bus_err    = r_bus_err;
    assign err_sticky = r_err_sticky;

    a_no_mreq_in_idle: assert property (@(posedge clk) disable iff (reset)
        (r_state == IDLE) |-> !r_m_req);
    a_acks_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(r_i_ack && r_d_ack));
    a_i_ack_pulse: assert property (@(posedge clk) disable iff (reset)
        r_i_ack |=> !r_i_ack);
    a_d_ack_pulse: assert property (@(posedge clk) disable iff (reset)
        r_d_ack |=> !r_d_ack);
    a_i_req_held: assert property (@(posedge clk) disable iff (reset)
        (r_state == I_XFER) |-> i_req);
    a_d_req_held: assert property (@(posedge clk) disable iff (reset)
        (r_state == D_XFER) |-> d_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, d_ack, stall, m_req, m_we, bus_err, err_sticky;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          force_cyc = -1;
    int          mem_delay = 1;
    logic [31:0] mem_key = '0;

    mem_arbiter #(.TIMEOUT(16), .DATA_FIRST(1)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .stall(stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input string nm, input int maxc);
        int n = 0;
        while (!(i_ack || d_ack) && n < maxc) begin
            step();
            n++;
        end
        check(nm, 32'(i_ack | d_ack), 32'd1);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    // Memory model: acks mem_delay cycles after m_req rises; mem_delay 0 never acks.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (m_ack) begin
                m_ack = 1'b0;
                cnt = 0;
            end else if (cyc == force_cyc) begin
                m_ack = 1'b1;
                m_rdata = 32'hBAD0_0BAD;
            end else if (m_req && mem_delay != 0) begin
                if (cnt == mem_delay) begin
                    m_ack = 1'b1;
                    m_rdata = m_addr ^ mem_key;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (i_ack || d_ack)) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b required none", i_ack, d_ack);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", 32'(d_ack), 32'(e.port));
                    check("ack_rdata", e.port ? d_rdata : i_rdata, e.rdata);
                    check("ack_bus_err", 32'(bus_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  exp_mreq, exp_stall, exp_iack;
        int          n, acks, hi;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // 1: instruction fetch, memory acks 2 cycles after m_req
        exp_mreq  = 5'b01110;
        exp_stall = 5'b01111;
        exp_iack  = 5'b10000;
        mem_delay = 2;
        mem_key   = 32'h1234_5638;
        push(1'b0, 32'h1234_5678, 1'b0);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) step();
            check($sformatf("t1_m_req_c%0d", c), 32'(m_req), 32'(exp_mreq[c]));
            check($sformatf("t1_stall_c%0d", c), 32'(stall), 32'(exp_stall[c]));
            check($sformatf("t1_i_ack_c%0d", c), 32'(i_ack), 32'(exp_iack[c]));
            if (c == 1) begin
                check("t1_m_addr", m_addr, 32'h40);
                check("t1_m_we", 32'(m_we), 32'd0);
            end
        end
        i_req = 1'b0;
        repeat (2) step();

        // 2: data write, 1-cycle memory
        mem_delay = 1;
        mem_key   = 32'hDEAD_BEEF;
        push(1'b1, 32'd0, 1'b0);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
        step();
        check("t2_m_req", 32'(m_req), 32'd1);
        check("t2_m_we", 32'(m_we), 32'd1);
        check("t2_m_addr", m_addr, 32'h100);
        check("t2_m_wdata", m_wdata, 32'hCAFE_F00D);
        wait_ack("t2_d_ack_seen", 10);
        d_we = 1'b0;
        repeat (2) step();

        // 3: both held from reset; alternation D, I, D, I
        @(negedge clk);
        reset = 1'b1;
        mem_delay = 1;
        mem_key   = 32'hA5A5_0000;
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        push(1'b1, 32'hA5A5_0300, 1'b0);
        push(1'b0, 32'hA5A5_0200, 1'b0);
        push(1'b1, 32'hA5A5_0300, 1'b0);
        push(1'b0, 32'hA5A5_0200, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        acks = 0;
        n = 0;
        while (acks < 4 && n < 40) begin
            step();
            n++;
            if (i_ack || d_ack) acks++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("t3_ack_count", 32'(acks), 32'd4);
        repeat (6) step();
        check("t3_no_regrant_m_req", 32'(m_req), 32'd0);

        // 4: data read, memory never acks -> timeout abort
        mem_delay = 0;
        push(1'b1, 32'd0, 1'b1);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
        #1;
        hi = 0;
        n = 0;
        while (!d_ack && n < 40) begin
            step();
            n++;
            if (m_req) hi++;
        end
        check("t4_m_req_cycles", 32'(hi), 32'd16);
        check("t4_d_ack", 32'(d_ack), 32'd1);
        check("t4_bus_err", 32'(bus_err), 32'd1);
        check("t4_d_rdata", d_rdata, 32'd0);
        check("t4_err_sticky", 32'(err_sticky), 32'd1);
        d_req = 1'b0;
        repeat (3) step();
        check("t4_sticky_holds", 32'(err_sticky), 32'd1);
        check("t4_bus_err_pulse", 32'(bus_err), 32'd0);

        // 6: m_ack exactly when the timer reaches TIMEOUT-1
        mem_delay = 15;
        mem_key   = 32'h5555_0000;
        push(1'b1, 32'h5555_0080, 1'b0);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        #1;
        wait_ack("t6_d_ack_seen", 30);
        check("t6_bus_err", 32'(bus_err), 32'd0);
        check("t6_err_sticky", 32'(err_sticky), 32'd1);
        repeat (2) step();

        // 5: asynchronous reset mid-transfer, then a stale m_ack
        mem_delay = 0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h44;
        repeat (3) step();
        check("t5_m_req_before", 32'(m_req), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_m_req_async", 32'(m_req), 32'd0);
        check("t5_m_addr_async", m_addr, 32'd0);
        check("t5_err_sticky_cleared", 32'(err_sticky), 32'd0);
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        force_cyc = cyc + 1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (i_ack || d_ack) acks++;
        end
        check("t5_stale_ack_ignored", 32'(acks), 32'd0);
        check("t5_m_req_idle", 32'(m_req), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the beta instruction-fetch port (ia/id) and the beta data port (memAddr/memWriteData/MemRead/MemWrite).
- Transfers are serialized through a small FSM with round-robin tie-break and a per-transfer watchdog.
- Exposes a stall so the top level can freeze the pc while either port is waiting.
- Sits between the beta core and the memory model/controller.

Parameters:
- TIMEOUT, 16: maximum cycles in a transfer state without m_ack before abort. Legal range is at least 2.
- DATA_FIRST, 1: if 1, the first tie after reset goes to data; if 0, it goes to instruction.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- i_req, input, 1: instruction fetch request. Held high until i_ack.
- i_addr, input, 32: fetch address, driven from ia.
- i_rdata, output, 32: fetched word, feeds id. Valid while i_ack is high.
- i_ack, output, 1: one-cycle completion pulse for a fetch.
- d_req, input, 1: data request, MemRead|MemWrite. Held high until d_ack.
- d_we, input, 1: 1 = write (MemWrite), 0 = read.
- d_addr, input, 32: data address (memAddr).
- d_wdata, input, 32: write data (memWriteData).
- d_rdata, output, 32: read data, feeds memReadData. Valid while d_ack is high.
- d_ack, output, 1: one-cycle completion pulse for a data transfer.
- stall, output, 1: high while either port is waiting, (i_req&~i_ack)|(d_req&~d_ack). Combinational.
- m_req, output, 1: memory request, registered.
- m_we, output, 1: memory write enable, registered.
- m_addr, output, 32: memory address, registered.
- m_wdata, output, 32: memory write data, registered.
- m_rdata, input, 32: memory read data. Valid when m_ack is high.
- m_ack, input, 1: memory completion, one cycle, at least 1 cycle after m_req rises.
- bus_err, output, 1: pulses together with i_ack/d_ack when a transfer was aborted by timeout.
- err_sticky, output, 1: set on any timeout. Cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs and data registers = 0; timer = 0; last_grant = INST if DATA_FIRST=1, else DATA. m_req drops immediately, including mid-transfer. A late m_ack after reset is ignored.
- States: IDLE, I_XFER, D_XFER.
- Eligibility in IDLE:
  - ireq_ok = i_req & ~i_ack; dreq_ok = d_req & ~d_ack.
  - A port whose ack is high this cycle is not eligible, so a held req cannot be re-granted.
- Grant in IDLE:
  - Only one eligible port: grant it.
  - Both eligible: grant the port that is not last_grant, then update last_grant.
  - Neither eligible: stay in IDLE.
- On grant, next edge:
  - Latch addr, we (instruction grant forces 0) and wdata into m_addr/m_we/m_wdata.
  - Set m_req=1, timer=0, enter the matching XFER state.
- In XFER:
  - m_req stays high; m_addr/m_we/m_wdata stay stable; timer increments each cycle.
  - m_ack=1: next edge drives m_req=0, captures m_rdata into the granted port's rdata, pulses that port's ack for 1 cycle, returns to IDLE. For writes, d_rdata = 0.
  - timer==TIMEOUT-1 with m_ack=0: next edge drives m_req=0, rdata=0, pulses ack and bus_err, sets err_sticky, returns to IDLE.
  - m_ack in the same cycle as timer==TIMEOUT-1: treated as success, no error.
- Latency: req high in cycle 0 (IDLE) -> m_req high cycle 1 -> m_ack cycle k (k≥1) -> ack high cycle k+1, with the state already IDLE.
  - Minimum round trip is 3 cycles.
  - A new grant to the other port can happen in cycle k+1, so back-to-back transfers alternate.
- Idle rdata: i_rdata/d_rdata hold their last value when ack is low; consumers must sample only with ack.
- m_ack received in IDLE: ignored.
- Requests dropped while in XFER: the transfer still completes and the ack is still pulsed. This is a requester protocol violation, flagged by an assertion.
- Widths: the timer is $clog2(TIMEOUT) bits and does not wrap; it is reset on every grant.
- Assertions:
  - m_req is never high in IDLE.
  - i_ack and d_ack are never high together.
  - i_ack/d_ack are never high for 2 consecutive cycles.

Decomposition:
- Shared package beta_pkg holds:
  - typedef enum arb_state_t {IDLE, I_XFER, D_XFER};
  - typedef enum logic grant_t {GNT_INST, GNT_DATA};
  - constant ARB_ERR_RDATA = 32'd0.
- One natural sub-module, mem_watchdog (parameter TIMEOUT):
  - Inputs: clk, reset, clear (on grant), run (in XFER).
  - Output: expire.
- The FSM, mux and registers stay in mem_arbiter.

Test Plan:
1. i_req=1, i_addr=32'h40, memory acks 2 cycles after m_req with m_rdata=32'h1234_5678 -> m_req high cycles 1-3, m_addr=32'h40, m_we=0; i_ack cycle 4 with i_rdata=32'h1234_5678; stall high cycles 0-3.
2. d_req=1, d_we=1, d_addr=32'h100, d_wdata=32'hCAFE_F00D, 1-cycle memory -> m_we=1, m_wdata=32'hCAFE_F00D; d_ack once; d_rdata=0.
3. i_req and d_req both high from reset, DATA_FIRST=1, 1-cycle memory -> grant order D, I, D, I across 4 transfers. Each port gets exactly one ack per grant; a req still high in its ack cycle is not re-granted.
4. d_req read, memory never acks, TIMEOUT=16 -> m_req drops after 16 cycles high; d_ack=1 and bus_err=1 together; d_rdata=0; err_sticky=1 and holds until reset.
5. reset asserted asynchronously mid-transfer while m_req=1 -> m_req and all outputs 0 in the same cycle; state IDLE; a stale m_ack afterwards produces no ack.
6. m_ack in the same cycle the timer reaches TIMEOUT-1 -> normal ack with captured data; bus_err=0; err_sticky unchanged.
